// File: rtl/fragment_scissor_alpha_test_if.sv
// Fragment stream interface (AXI-Stream style) between pixel pipeline stages.
// Ports (master drives):
//   tvalid, tlast, tkeep          handshake and framing
//   tfragment_color               {R,G,B,A}, A in the least significant byte
//   tindex, tscreen_pos_x/y       framebuffer index and screen position
//   tdepth                        32-bit depth
// Slave drives tready.
interface fragment_scissor_alpha_test_if #(
    parameter int INDEX_WIDTH      = 14,
    parameter int SUB_PIXEL_WIDTH  = 8,
    parameter int SCREEN_POS_WIDTH = 11
);
    localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

    logic                        tvalid;
    logic                        tready;
    logic                        tlast;
    logic                        tkeep;
    logic [PIXEL_WIDTH-1:0]      tfragment_color;
    logic [INDEX_WIDTH-1:0]      tindex;
    logic [SCREEN_POS_WIDTH-1:0] tscreen_pos_x;
    logic [SCREEN_POS_WIDTH-1:0] tscreen_pos_y;
    logic [31:0]                 tdepth;

    modport master (
        output tvalid, tlast, tkeep, tfragment_color, tindex,
               tscreen_pos_x, tscreen_pos_y, tdepth,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tkeep, tfragment_color, tindex,
               tscreen_pos_x, tscreen_pos_y, tdepth,
        output tready
    );
endinterface

// File: rtl/fragment_scissor_alpha_test.sv
// Per-fragment scissor and alpha test. Fragments are never dropped: a failing
// fragment leaves with keep=0, so ordering and tlast survive to the framebuffer.
// Two register stages (compare results, then final keep); 1 beat/cycle.
// Ports:
//   aclk, resetn            clock, async active-low reset (deassertion is
//                           expected to be synchronous to aclk)
//   conf*                   scissor rectangle / alpha test configuration,
//                           sampled when a fragment is accepted
//   s_frag (slave)          input fragment stream
//   m_frag (master)         output fragment stream, same fields
//   statFragCount/KillCount counts for the last completed frame
//   statValid               1-cycle pulse when stat counts update
module fragment_scissor_alpha_test #(
    parameter int INDEX_WIDTH      = 14,
    parameter int SUB_PIXEL_WIDTH  = 8,
    parameter int SCREEN_POS_WIDTH = 11
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        confEnableScissor,
    input  logic                        confEnableAlpha,
    input  logic [2:0]                  confAlphaFunc,
    input  logic [SUB_PIXEL_WIDTH-1:0]  confAlphaRef,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorX,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorY,
    input  logic [SCREEN_POS_WIDTH:0]   confScissorW,
    input  logic [SCREEN_POS_WIDTH:0]   confScissorH,
    fragment_scissor_alpha_test_if.slave  s_frag,
    fragment_scissor_alpha_test_if.master m_frag,
    output logic [31:0]                 statFragCount,
    output logic [31:0]                 statKillCount,
    output logic                        statValid
);
    localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;
    localparam int SPOS = SCREEN_POS_WIDTH;
    localparam int SW   = SCREEN_POS_WIDTH + 2;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] color;
        logic [INDEX_WIDTH-1:0] index;
        logic [SPOS-1:0]        x;
        logic [SPOS-1:0]        y;
        logic [31:0]            depth;
        logic                   last;
    } beat_t;

    logic        v1_q, v1_d, v2_q, v2_d;
    beat_t       s1_beat_q, s1_beat_d, s2_beat_q, s2_beat_d;
    logic        s1_keep_q, s1_keep_d, s1_sc_pass_q, s1_sc_pass_d;
    logic        s1_al_pass_q, s1_al_pass_d;
    logic        s2_in_keep_q, s2_in_keep_d, s2_keep_q, s2_keep_d;
    logic [31:0] run_frag_q, run_frag_d, run_kill_q, run_kill_d;
    logic [31:0] stat_frag_q, stat_frag_d, stat_kill_q, stat_kill_d;
    logic        stat_valid_q, stat_valid_d;

    logic        en1, en2, out_hs;
    logic        sc_pass, al_pass;
    logic [SW-1:0] x_w, y_w, x_lo, y_lo, x_hi, y_hi;
    logic [SUB_PIXEL_WIDTH-1:0] alpha;
    logic [31:0] frag_next, kill_next;

    // Ready ripples combinationally from m_frag.tready so a full pipeline
    // still moves one beat per cycle.
    assign en2    = !v2_q || m_frag.tready;
    assign en1    = !v1_q || en2;
    assign out_hs = v2_q && m_frag.tready;
    assign s_frag.tready = en1;

    // Extended by two bits so X+W cannot wrap; W=0 gives an empty range.
    assign x_w  = SW'(s_frag.tscreen_pos_x);
    assign y_w  = SW'(s_frag.tscreen_pos_y);
    assign x_lo = SW'(confScissorX);
    assign y_lo = SW'(confScissorY);
    assign x_hi = SW'(confScissorX) + SW'(confScissorW);
    assign y_hi = SW'(confScissorY) + SW'(confScissorH);
    assign alpha = s_frag.tfragment_color[SUB_PIXEL_WIDTH-1:0];

    always_comb begin
        sc_pass = 1'b1;
        if (confEnableScissor)
            sc_pass = (x_w >= x_lo) && (x_w < x_hi) && (y_w >= y_lo) && (y_w < y_hi);
        al_pass = 1'b1;
        if (confEnableAlpha) begin
            case (confAlphaFunc)
                3'd0:    al_pass = 1'b0;
                3'd1:    al_pass = alpha <  confAlphaRef;
                3'd2:    al_pass = alpha == confAlphaRef;
                3'd3:    al_pass = alpha <= confAlphaRef;
                3'd4:    al_pass = alpha >  confAlphaRef;
                3'd5:    al_pass = alpha != confAlphaRef;
                3'd6:    al_pass = alpha >= confAlphaRef;
                default: al_pass = 1'b1;
            endcase
        end
    end

    always_comb begin
        v1_d         = v1_q;
        s1_beat_d    = s1_beat_q;
        s1_keep_d    = s1_keep_q;
        s1_sc_pass_d = s1_sc_pass_q;
        s1_al_pass_d = s1_al_pass_q;
        v2_d         = v2_q;
        s2_beat_d    = s2_beat_q;
        s2_in_keep_d = s2_in_keep_q;
        s2_keep_d    = s2_keep_q;
        run_frag_d   = run_frag_q;
        run_kill_d   = run_kill_q;
        stat_frag_d  = stat_frag_q;
        stat_kill_d  = stat_kill_q;
        stat_valid_d = 1'b0;
        frag_next    = run_frag_q + 32'(s2_in_keep_q);
        kill_next    = run_kill_q + 32'(s2_in_keep_q && !s2_keep_q);

        if (en1) begin
            v1_d = s_frag.tvalid;
            if (s_frag.tvalid) begin
                s1_beat_d    = '{color: s_frag.tfragment_color, index: s_frag.tindex,
                                 x: s_frag.tscreen_pos_x, y: s_frag.tscreen_pos_y,
                                 depth: s_frag.tdepth, last: s_frag.tlast};
                s1_keep_d    = s_frag.tkeep;
                s1_sc_pass_d = sc_pass;
                s1_al_pass_d = al_pass;
            end
        end

        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_beat_d    = s1_beat_q;
                s2_in_keep_d = s1_keep_q;
                s2_keep_d    = s1_keep_q && s1_sc_pass_q && s1_al_pass_q;
            end
        end

        // Stats include the tlast beat itself; running counts restart at 0.
        if (out_hs) begin
            if (s2_beat_q.last) begin
                stat_frag_d  = frag_next;
                stat_kill_d  = kill_next;
                stat_valid_d = 1'b1;
                run_frag_d   = '0;
                run_kill_d   = '0;
            end else begin
                run_frag_d = frag_next;
                run_kill_d = kill_next;
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            v1_q         <= 1'b0;
            s1_beat_q    <= '0;
            s1_keep_q    <= 1'b0;
            s1_sc_pass_q <= 1'b0;
            s1_al_pass_q <= 1'b0;
            v2_q         <= 1'b0;
            s2_beat_q    <= '0;
            s2_in_keep_q <= 1'b0;
            s2_keep_q    <= 1'b0;
            run_frag_q   <= '0;
            run_kill_q   <= '0;
            stat_frag_q  <= '0;
            stat_kill_q  <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            s1_beat_q    <= s1_beat_d;
            s1_keep_q    <= s1_keep_d;
            s1_sc_pass_q <= s1_sc_pass_d;
            s1_al_pass_q <= s1_al_pass_d;
            v2_q         <= v2_d;
            s2_beat_q    <= s2_beat_d;
            s2_in_keep_q <= s2_in_keep_d;
            s2_keep_q    <= s2_keep_d;
            run_frag_q   <= run_frag_d;
            run_kill_q   <= run_kill_d;
            stat_frag_q  <= stat_frag_d;
            stat_kill_q  <= stat_kill_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign m_frag.tvalid          = v2_q;
    assign m_frag.tlast           = s2_beat_q.last;
    assign m_frag.tkeep           = s2_keep_q;
    assign m_frag.tfragment_color = s2_beat_q.color;
    assign m_frag.tindex          = s2_beat_q.index;
    assign m_frag.tscreen_pos_x   = s2_beat_q.x;
    assign m_frag.tscreen_pos_y   = s2_beat_q.y;
    assign m_frag.tdepth          = s2_beat_q.depth;
    assign statFragCount          = stat_frag_q;
    assign statKillCount          = stat_kill_q;
    assign statValid              = stat_valid_q;
endmodule

// File: tb/tb_fragment_scissor_alpha_test.sv
module tb_fragment_scissor_alpha_test;
    typedef struct packed {
        logic [31:0] color;
        logic [13:0] index;
        logic [10:0] x;
        logic [10:0] y;
        logic [31:0] depth;
        logic        keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] frag;
        logic [31:0] kill;
    } stat_t;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        en_sc = 1'b0, en_al = 1'b0;
    logic [2:0]  func = 3'd7;
    logic [7:0]  aref = 8'd0;
    logic [10:0] sx = '0, sy = '0;
    logic [11:0] sw = '0, sh = '0;
    logic [31:0] stat_frag, stat_kill;
    logic        stat_valid;

    fragment_scissor_alpha_test_if s_if ();
    fragment_scissor_alpha_test_if m_if ();

    fragment_scissor_alpha_test dut (
        .aclk(aclk), .resetn(resetn),
        .confEnableScissor(en_sc), .confEnableAlpha(en_al),
        .confAlphaFunc(func), .confAlphaRef(aref),
        .confScissorX(sx), .confScissorY(sy), .confScissorW(sw), .confScissorH(sh),
        .s_frag(s_if), .m_frag(m_if),
        .statFragCount(stat_frag), .statKillCount(stat_kill), .statValid(stat_valid)
    );

    always #5 aclk = ~aclk;

    int    errors = 0, checks = 0;
    int    exp_frag = 0, exp_kill = 0;
    int    rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low
    beat_t exp_q[$];
    stat_t stat_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output ready generator, changes only just after the rising edge.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: compares every output handshake and stat pulse.
    beat_t prev_beat;
    logic  held = 1'b0;
    always @(negedge aclk) begin
        beat_t cur;
        stat_t st;
        cur = '{color: m_if.tfragment_color, index: m_if.tindex, x: m_if.tscreen_pos_x,
                y: m_if.tscreen_pos_y, depth: m_if.tdepth, keep: m_if.tkeep, last: m_if.tlast};
        if (!resetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 128'(m_if.tvalid), 128'(1));
                check("hold_payload", 128'(cur), 128'(prev_beat));
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %h expected none", cur);
                end else begin
                    check("beat", 128'(cur), 128'(exp_q.pop_front()));
                end
            end
            held = m_if.tvalid && !m_if.tready;
            prev_beat = cur;
            if (stat_valid) begin
                st = '{frag: stat_frag, kill: stat_kill};
                if (stat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_stat: got %h expected none", st);
                end else begin
                    check("stats", 128'(st), 128'(stat_q.pop_front()));
                end
            end
        end
    end

    // Issue one beat; exp_keep is the hand-computed output keep.
    task automatic send(input beat_t b, input logic exp_keep);
        beat_t e;
        logic  acc;
        e = b;
        e.keep = exp_keep;
        exp_q.push_back(e);
        if (b.keep) exp_frag++;
        if (b.keep && !exp_keep) exp_kill++;
        if (b.last) begin
            stat_q.push_back('{frag: 32'(exp_frag), kill: 32'(exp_kill)});
            exp_frag = 0;
            exp_kill = 0;
        end
        s_if.tvalid = 1'b1;
        s_if.tfragment_color = b.color;
        s_if.tindex = b.index;
        s_if.tscreen_pos_x = b.x;
        s_if.tscreen_pos_y = b.y;
        s_if.tdepth = b.depth;
        s_if.tkeep = b.keep;
        s_if.tlast = b.last;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge aclk);
            acc = s_if.tready;
            @(posedge aclk);
            #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got tready=0 expected 1");
        end
        s_if.tvalid = 1'b0;
    endtask

    function automatic beat_t mk(input logic [10:0] x, input logic [7:0] a,
                                 input logic keep, input logic last);
        return '{color: {24'h123456, a}, index: 14'(x) ^ 14'h2a5, x: x, y: 11'd3,
                 depth: 32'hdead0000 | 32'(x), keep: keep, last: last};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    initial begin
        beat_t b;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tkeep = 1'b0;
        s_if.tfragment_color = '0; s_if.tindex = '0; s_if.tdepth = '0;
        s_if.tscreen_pos_x = '0; s_if.tscreen_pos_y = '0;

        // Reset state
        cycles(2);
        check("rst_m_tvalid", 128'(m_if.tvalid), 128'(0));
        check("rst_stat_valid", 128'(stat_valid), 128'(0));
        check("rst_stat_frag", 128'(stat_frag), 128'(0));
        check("rst_stat_kill", 128'(stat_kill), 128'(0));
        check("rst_s_tready", 128'(s_if.tready), 128'(1));
        check("rst_m_payload", 128'({m_if.tfragment_color, m_if.tdepth, m_if.tindex}), 128'(0));
        resetn = 1'b1;
        cycles(2);

        // Both tests disabled: bit-exact passthrough under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            b.color = $urandom; b.index = 14'($urandom); b.x = 11'($urandom);
            b.y = 11'($urandom); b.depth = $urandom; b.keep = 1'($urandom_range(0, 1));
            b.last = (i % 25 == 24);
            send(b, b.keep);
        end
        rdy_mode = 0;
        cycles(4);

        // Scissor X=10 W=5 (Y=0, H covers the whole screen)
        en_sc = 1'b1; sx = 11'd10; sw = 12'd5; sy = 11'd0; sh = 12'd2048;
        send(mk(11'd9,  8'h00, 1, 0), 1'b0);
        send(mk(11'd10, 8'h00, 1, 0), 1'b1);
        send(mk(11'd14, 8'h00, 1, 0), 1'b1);
        send(mk(11'd15, 8'h00, 1, 0), 1'b0);
        sw = 12'd0;
        send(mk(11'd10, 8'h00, 1, 0), 1'b0);
        send(mk(11'd12, 8'h00, 1, 0), 1'b0);
        sx = 11'd2040; sw = 12'd8;
        send(mk(11'd2047, 8'h00, 1, 0), 1'b1);
        send(mk(11'd2039, 8'h00, 1, 0), 1'b0);

        // Alpha tests
        en_sc = 1'b0; en_al = 1'b1;
        func = 3'd4; aref = 8'h80;
        send(mk(11'd1, 8'h80, 1, 0), 1'b0);
        send(mk(11'd2, 8'h81, 1, 0), 1'b1);
        func = 3'd1;
        send(mk(11'd3, 8'h7f, 1, 0), 1'b1);
        func = 3'd0;
        send(mk(11'd4, 8'hff, 1, 0), 1'b0);
        func = 3'd7;
        send(mk(11'd5, 8'h00, 1, 0), 1'b1);
        func = 3'd2; aref = 8'h00;
        send(mk(11'd6, 8'h00, 1, 1), 1'b1);

        // Frame of 8: one tkeep=0, three failing -> stats 7 / 3
        en_al = 1'b0; en_sc = 1'b1; sx = 11'd10; sw = 12'd5;
        send(mk(11'd10, 8'h00, 1, 0), 1'b1);
        send(mk(11'd11, 8'h00, 1, 0), 1'b1);
        send(mk(11'd9,  8'h00, 1, 0), 1'b0);
        send(mk(11'd12, 8'h00, 0, 0), 1'b0);
        send(mk(11'd15, 8'h00, 1, 0), 1'b0);
        send(mk(11'd13, 8'h00, 1, 0), 1'b1);
        send(mk(11'd14, 8'h00, 1, 0), 1'b1);
        send(mk(11'd20, 8'h00, 1, 1), 1'b0);
        cycles(4);

        // Backpressure: two beats in flight, ready low for 5 cycles
        en_sc = 1'b0;
        rdy_mode = 2;
        cycles(1);
        send(mk(11'd100, 8'h11, 1, 0), 1'b1);
        send(mk(11'd101, 8'h22, 1, 0), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("stall_s_tready", 128'(s_if.tready), 128'(0));
            check("stall_m_tvalid", 128'(m_if.tvalid), 128'(1));
            @(posedge aclk); #1;
        end
        rdy_mode = 0;
        send(mk(11'd102, 8'h33, 1, 1), 1'b1);
        cycles(4);

        // Reset mid-frame: counted and in-flight beats are both forgotten
        send(mk(11'd200, 8'h00, 1, 0), 1'b1);
        send(mk(11'd201, 8'h00, 1, 0), 1'b1);
        cycles(3);
        rdy_mode = 2;
        cycles(1);
        send(mk(11'd202, 8'h00, 1, 0), 1'b1);
        send(mk(11'd203, 8'h00, 1, 0), 1'b1);
        resetn = 1'b0;
        #1;
        check("midrst_m_tvalid", 128'(m_if.tvalid), 128'(0));
        check("midrst_stat_valid", 128'(stat_valid), 128'(0));
        exp_q.delete();
        exp_frag = 0;
        exp_kill = 0;
        rdy_mode = 0;
        cycles(2);
        resetn = 1'b1;
        cycles(1);
        send(mk(11'd300, 8'h00, 1, 0), 1'b1);
        en_al = 1'b1; func = 3'd0;
        send(mk(11'd301, 8'h00, 1, 1), 1'b0);
        en_al = 1'b0;

        // Drain
        for (int i = 0; i < 100 && (exp_q.size() != 0 || stat_q.size() != 0); i++) cycles(1);
        cycles(3);
        check("drain_beats_left", 128'(exp_q.size()), 128'(0));
        check("drain_stats_left", 128'(stat_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
